// File: rtl/sf_trace_capture.sv
// Trace capture buffer: records strobed trace words into a circular RAM, freezes a
// window around a host stop request, and serves the samples back oldest-first.
//
// state | meaning
// IDLE  | no capture since reset; strobes dropped
// RUN   | capturing, overwriting the oldest entries when full
// POST  | capturing the remaining post-stop samples
// DONE  | frozen; buffer readable, strobes dropped
module sf_trace_capture #(
  parameter int tw = 22,
  parameter int aw = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic signed [tw-1:0] trace,
  input  logic                 trace_strobe,
  input  logic                 arm,
  input  logic                 stop,
  input  logic [aw-1:0]        post_count,
  input  logic [aw-1:0]        h_addr,
  output logic signed [tw-1:0] h_data,
  output logic [1:0]           state,
  output logic [aw:0]          count
);

  localparam int d = 2**aw;
  localparam logic [aw:0] count_full = {1'b1, {aw{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               st;
  logic [aw-1:0]        wr_ptr;
  logic [aw-1:0]        remaining;
  logic [aw-1:0]        ra;
  logic                 filled;
  logic                 wev;
  logic                 wrap;
  logic signed [tw-1:0] mem [d];

  // arm wins over a same-cycle strobe, so that sample never reaches the RAM
  assign wev   = ce & trace_strobe & ((st == RUN) | (st == POST)) & ~arm;
  assign wrap  = &wr_ptr;
  assign ra    = filled ? wr_ptr + h_addr : h_addr;
  assign state = st;

  always_ff @(posedge clk) begin
    if (wev) mem[wr_ptr] <= trace;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) h_data <= '0;
    else     h_data <= mem[ra];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      filled    <= 1'b0;
      remaining <= '0;
      count     <= '0;
    end else if (arm) begin
      st        <= RUN;
      wr_ptr    <= '0;
      filled    <= 1'b0;
      remaining <= '0;
      count     <= '0;
    end else begin
      if (wev) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wrap) filled <= 1'b1;
        count <= (filled | wrap) ? count_full : {1'b0, wr_ptr + 1'b1};
      end
      case (st)
        RUN: begin
          // a write in the stop cycle belongs to the pre-stop window
          if (stop) begin
            if (post_count == '0) begin
              st <= DONE;
            end else begin
              st        <= POST;
              remaining <= post_count;
            end
          end
        end
        POST: begin
          if (wev) begin
            remaining <= remaining - 1'b1;
            if (remaining == aw'(1)) st <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sf_trace_capture.sv
// Bench for sf_trace_capture (aw=3): directed vector table, hand sequences for
// wrap/post/priority/reset corners, and random traffic against a queue model.
module tb_sf_trace_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [21:0] trace;
  logic        trace_strobe;
  logic        arm;
  logic        stop;
  logic [2:0]  post_count;
  logic [2:0]  h_addr;
  logic [21:0] h_data;
  logic [1:0]  state;
  logic [3:0]  count;

  sf_trace_capture #(.tw(22), .aw(3)) dut (
    .clk(clk), .rst(rst), .ce(ce), .trace(trace), .trace_strobe(trace_strobe),
    .arm(arm), .stop(stop), .post_count(post_count), .h_addr(h_addr),
    .h_data(h_data), .state(state), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // model: last (up to 8) samples since arm, oldest first
  int          m_state;
  int          m_left;
  logic [21:0] q[$];

  typedef struct {
    bit arm;
    bit stop;
    bit ce;
    bit stb;
    int tr;
    int pc;
    int exp_state;
    int exp_count;
  } vec_t;
  vec_t tv[11];

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_left  = 0;
    q.delete();
  endtask

  task automatic model_update();
    bit wr;
    if (arm) begin
      m_state = 1;
      m_left  = 0;
      q.delete();
    end else begin
      wr = ce && trace_strobe && (m_state == 1 || m_state == 2);
      if (wr) begin
        q.push_back(trace);
        if (q.size() > 8) void'(q.pop_front());
      end
      if (m_state == 1 && stop) begin
        if (post_count == 0) m_state = 3;
        else begin
          m_state = 2;
          m_left  = int'(post_count);
        end
      end else if (m_state == 2 && wr) begin
        m_left--;
        if (m_left == 0) m_state = 3;
      end
    end
  endtask

  // one clock with the current inputs; checks outputs against the model
  task automatic step();
    bit          hv;
    logic [21:0] hexp;
    hv   = (m_state == 3) && (int'(h_addr) < q.size());
    hexp = hv ? q[h_addr] : '0;
    @(posedge clk);
    model_update();
    #1;
    chk("state", int'(state), m_state);
    chk("count", int'(count), q.size());
    if (hv) chk("h_data", int'(h_data), int'(hexp));
  endtask

  task automatic drive(bit a, bit s, bit c, bit t, int tr, int pc);
    arm          = a;
    stop         = s;
    ce           = c;
    trace_strobe = t;
    trace        = 22'(tr);
    post_count   = 3'(pc);
    step();
    arm          = 1'b0;
    stop         = 1'b0;
    ce           = 1'b0;
    trace_strobe = 1'b0;
  endtask

  task automatic read_chk(string nm, int addr, int exp);
    h_addr = 3'(addr);
    step();
    chk(nm, int'(h_data), exp);
  endtask

  initial begin
    tv[0]  = '{1, 0, 0, 0,  0, 0, 1, 0};
    tv[1]  = '{0, 0, 1, 1,  1, 0, 1, 1};
    tv[2]  = '{0, 0, 0, 1, 99, 0, 1, 1};
    tv[3]  = '{0, 0, 1, 0, 98, 0, 1, 1};
    tv[4]  = '{0, 0, 1, 1,  2, 0, 1, 2};
    tv[5]  = '{0, 0, 1, 1,  3, 0, 1, 3};
    tv[6]  = '{0, 0, 0, 1, 97, 0, 1, 3};
    tv[7]  = '{0, 0, 1, 1,  4, 0, 1, 4};
    tv[8]  = '{0, 0, 1, 1,  5, 0, 1, 5};
    tv[9]  = '{0, 1, 0, 0,  0, 0, 3, 5};
    tv[10] = '{0, 0, 1, 1, 77, 0, 3, 5};

    rst = 1'b1; ce = 1'b0; trace = '0; trace_strobe = 1'b0;
    arm = 1'b0; stop = 1'b0; post_count = '0; h_addr = '0;
    model_reset();
    #3;
    chk("rst_state", int'(state), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_h_data", int'(h_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // no wrap, mixed ce / strobe gaps, strobes ignored in DONE
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].arm, tv[i].stop, tv[i].ce, tv[i].stb, tv[i].tr, tv[i].pc);
      chk("tv_state", int'(state), tv[i].exp_state);
      chk("tv_count", int'(count), tv[i].exp_count);
    end
    for (int i = 0; i < 5; i++) read_chk("nowrap_rd", i, i + 1);

    // wrap: 11 samples leave 4..11
    drive(1, 0, 0, 0, 0, 0);
    for (int v = 1; v <= 11; v++) drive(0, 0, 1, 1, v, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("wrap_state", int'(state), 3);
    chk("wrap_count", int'(count), 8);
    for (int i = 0; i < 8; i++) read_chk("wrap_rd", i, i + 4);

    // post-stop window: stop with sample 12, three more samples
    drive(1, 0, 0, 0, 0, 0);
    for (int v = 1; v <= 20; v++) begin
      drive(0, v == 12, 1, 1, v, 3);
      if (v >= 12 && v < 15) chk("post_state", int'(state), 2);
      if (v >= 15) chk("post_done", int'(state), 3);
    end
    chk("post_count", int'(count), 8);
    for (int i = 0; i < 8; i++) read_chk("post_rd", i, i + 8);

    // re-arm from a wrapped DONE
    drive(1, 0, 0, 0, 0, 0);
    chk("rearm_count", int'(count), 0);
    drive(0, 0, 1, 1, 2, 0);
    drive(0, 0, 1, 1, 3, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("rearm_cnt2", int'(count), 2);
    read_chk("rearm_rd", 0, 2);
    read_chk("rearm_rd", 1, 3);

    // arm + stop + strobe together: RUN, sample discarded
    drive(1, 1, 1, 1, 55, 2);
    chk("prio_state", int'(state), 1);
    chk("prio_count", int'(count), 0);
    drive(0, 0, 1, 1, 9, 0);
    drive(0, 1, 0, 0, 0, 0);
    read_chk("prio_rd", 0, 9);

    // reset mid-capture, async
    drive(1, 0, 0, 0, 0, 0);
    for (int v = 1; v <= 5; v++) drive(0, 0, 1, 1, v + 40, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_h_data", int'(h_data), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 1, 1, 1, 33, 0);
    chk("idle_stop", int'(state), 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 7, 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("after_rst_count", int'(count), 1);
    read_chk("after_rst_rd", 0, 7);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      h_addr = 3'($urandom_range(0, 7));
      drive(($urandom % 40) == 0, ($urandom % 25) == 0, ($urandom % 4) != 0,
            ($urandom % 3) != 0, int'($urandom & 32'h3f_ffff), int'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sf_trace_capture.md
Name: sf_trace_capture

Overview:
- Downstream consumer of the sf_user trace stream: captures trace words, qualified by trace_strobe and ce, into a circular buffer.
- Freezes a window around a host stop request, then lets the host read samples back oldest-first through a synchronous read port.
- Sits between the sf_user wrappers and the host register/readout bus.

Parameters:
- tw, 22, trace word width (matches pw+extra of the upstream stage)
- aw, 10, buffer address width; depth D = 2**aw

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ce  input  1  clock enable from the upstream stage; qualifies sample writes only
- trace  input  tw  signed trace word from sf_user
- trace_strobe  input  1  trace word valid
- arm  input  1  single-cycle pulse: clear buffer and start capture
- stop  input  1  single-cycle pulse: begin post-stop countdown
- post_count  input  aw  number of samples to write after stop; latched on stop
- h_addr  input  aw  host read index; 0 = oldest stored sample
- h_data  output  tw  read data; registered, 1-cycle latency
- state  output  2  0 IDLE, 1 RUN, 2 POST, 3 DONE
- count  output  aw+1  number of valid samples held (0..D)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, wr_ptr=0, filled=0, remaining=0, h_data=0, count=0.
  - RAM contents are not reset.
- Write event (wev) = ce & trace_strobe & (state==RUN | state==POST).
  - On wev: RAM[wr_ptr] <= trace; wr_ptr <= wr_ptr+1 mod D.
  - The cycle where wr_ptr goes D-1 -> 0 sets filled=1 (sticky until arm/reset).
- count = filled ? D : wr_ptr, registered along with the pointer, so it reflects writes one cycle later.
- FSM transitions, evaluated every clock regardless of ce:
  - Any state, arm=1 -> RUN; wr_ptr=0, filled=0. arm has priority over stop and over any same-cycle write, so that sample is discarded.
  - RUN, stop=1, post_count==0 -> DONE.
  - RUN, stop=1, post_count!=0 -> POST; remaining <= post_count.
  - A wev in the same cycle as stop is written as a RUN sample and is not counted against post_count.
  - POST: each wev decrements remaining; the wev with remaining==1 writes its sample and moves to DONE. Exactly post_count samples are written after the stop cycle.
  - IDLE/POST/DONE: stop is ignored.
  - DONE: holds until arm or reset. trace_strobe is ignored and no writes occur.
- Read port:
  - Physical address ra = filled ? (wr_ptr + h_addr) mod D : h_addr.
  - h_data <= RAM[ra] on every clock, giving 1-cycle latency.
  - Reads have no side effects and may be issued in any state.
  - Contents are only guaranteed coherent in DONE. h_addr >= count returns stale or unspecified data.
- Wrap-around: in RUN the buffer overwrites the oldest entries indefinitely. In DONE, h_addr 0..D-1 spans the last D samples, oldest first.
- No back-pressure: the upstream stage never stalls, and every strobe is either captured or dropped according to state.
- RAM: simple dual-port, written and read on clk. Inference-friendly: no reset on the array, registered read.

Test Plan (aw=3, D=8, tw=22):
- Reset mid-capture: arm, write 5 samples, assert rst for 1 cycle -> state=0, count=0, h_data=0 immediately (async). A following arm starts cleanly at wr_ptr=0.
- No wrap: arm, write values 1..5 with strobes interleaved with ce=0 cycles and strobe-only cycles, stop with post_count=0 -> state=3, count=5. h_addr=0..4 returns 1..5, each 1 cycle after the address.
- Wrap: arm, write 1..11, stop with post_count=0 -> count=8. h_addr=0..7 returns 4..11.
- Post-stop window: arm, write 1..20 with stop coincident with sample 12 and post_count=3 -> state goes 2 then 3 after sample 15. Samples 16..20 are ignored. Buffer reads 8..15.
- Priority and ignore rules:
  - arm and stop in the same cycle, with a strobe -> state=RUN, count=0, sample discarded.
  - stop while IDLE -> state stays 0.
  - Strobes while DONE -> count and contents unchanged.
- Re-arm from DONE after a wrapped capture -> filled cleared, count=0. Writing 2,3 then stop with post_count=0 reads back 2,3 at h_addr 0,1.
